// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Imported by the fetch stage and its IF/ID register.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with stall hold and flush.
// Flush wins over stall; an empty slot always carries a NOP.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              load,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [31:0]       in_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [31:0]       instr
);

    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] pc4_d, pc4_q;
    logic [31:0]       instr_d, instr_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                pc4_d   = in_pc + ADDR_W'(4);
                instr_d = in_instr;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign pc4   = pc4_q;
    assign instr = instr_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem handshake, skid buffer
// for stalls and redirect handling, feeding the IF/ID register.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4,
    output logic [31:0]       id_instr
);

    localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] ALIGN  = ~ADDR_W'(3);

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] req_pc_d, req_pc_q;
    logic              buf_valid_d, buf_valid_q;
    logic [ADDR_W-1:0] buf_pc_d, buf_pc_q;
    logic [31:0]       buf_instr_d, buf_instr_q;

    logic              id_load;
    logic [ADDR_W-1:0] id_in_pc;
    logic [31:0]       id_in_instr;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        id_load     = 1'b0;
        id_in_pc    = req_pc_q;
        id_in_instr = imem_rdata;

        unique case (state_q)
            FETCH: begin
                if (imem_gnt) begin
                    pc_d     = pc_q + ADDR_W'(4);
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (!stall) begin
                        id_load = 1'b1;
                        state_d = FETCH;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_pc_q;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                id_in_pc    = buf_pc_q;
                id_in_instr = buf_instr_q;
                if (!stall) begin
                    id_load     = 1'b1;
                    buf_valid_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
        endcase

        // A response still in flight after a redirect must be swallowed.
        if (redirect) begin
            pc_d        = redirect_pc & ALIGN;
            buf_valid_d = 1'b0;
            if ((state_q == FETCH && imem_gnt) ||
                (state_q == WAIT && !imem_rvalid)) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= PC_RST;
            req_pc_q    <= PC_RST;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_req  = (state_q == FETCH) && !rst;
    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (redirect),
        .load    (id_load),
        .in_pc   (id_in_pc),
        .in_instr(id_in_instr),
        .valid   (id_valid),
        .pc      (id_pc),
        .pc4     (id_pc4),
        .instr   (id_instr)
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed + randomized bench for mips_fetch_stage against a
// transaction-level model of fetch order, delivery order and flushes.
module tb_mips_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    mips_fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_instr   (id_instr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // memory model and expectation state
    bit          pending, buffered, dropflag, hold_req;
    int          delay;
    logic [31:0] paddr, hold_addr, exp_fetch, exp_deliv;
    int          accept_pct, lat_max;
    logic        pv;
    logic [31:0] ppc, ppc4, pinstr;
    bit          d;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]} | 32'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_clear();
        pending   = 0;
        buffered  = 0;
        dropflag  = 0;
        hold_req  = 0;
        delay     = 0;
        paddr     = '0;
        hold_addr = '0;
        exp_fetch = RESET_PC_DEF;
        exp_deliv = RESET_PC_DEF;
        pv        = 0;
        ppc       = '0;
        ppc4      = '0;
        pinstr    = '0;
    endtask

    task automatic do_reset(input bit mid);
        rst = 1'b1;
        #1;
        if (!mid) begin
            @(posedge clk);
            #1;
        end
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC_DEF);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_pc4", id_pc4, 32'd0);
        chk("rst_id_instr", id_instr, NOP_INSTR);
        imem_gnt    = 0;
        imem_rvalid = 0;
        imem_rdata  = '0;
        stall       = 0;
        redirect    = 0;
        redirect_pc = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // cond: 0 any time, 1 only while waiting with no rvalid, 2 only with gnt
    task automatic cycle(input bit st, input bit rd_en, input logic [31:0] rpc,
                         input int cond, output bit did);
        logic        req_n;
        logic [31:0] addr_n;
        bit          a_gnt, a_rv, a_rd, granted, newi;
        @(negedge clk);
        req_n  = imem_req;
        addr_n = imem_addr;
        chk("addr_align", 32'(addr_n[1:0]), 32'd0);
        if (pending || buffered || dropflag)
            chk("req_while_busy", 32'(req_n), 32'd0);
        if (hold_req) begin
            chk("req_stable", 32'(req_n), 32'd1);
            chk("addr_stable", addr_n, hold_addr);
        end
        a_gnt = req_n && ($urandom_range(99) < 32'(accept_pct));
        a_rv  = pending && delay == 0;
        a_rd  = rd_en && !dropflag &&
                (cond == 0 || (cond == 1 && pending && delay > 0) ||
                 (cond == 2 && a_gnt));
        imem_gnt    = a_gnt;
        imem_rvalid = a_rv;
        imem_rdata  = a_rv ? memw(paddr) : $urandom;
        stall       = st;
        redirect    = a_rd;
        redirect_pc = rpc;
        did         = a_rd;
        @(posedge clk);
        #1;
        granted = req_n && a_gnt;
        if (granted) begin
            chk("fetch_addr", addr_n, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pending   = 1;
            paddr     = addr_n;
            delay     = $urandom_range(lat_max);
        end else if (a_rv) begin
            pending = 0;
        end else if (pending && delay > 0) begin
            delay--;
        end
        if (a_rd) begin
            chk("flush_valid", 32'(id_valid), 32'd0);
            chk("flush_instr", id_instr, NOP_INSTR);
            exp_fetch = rpc & ~32'd3;
            exp_deliv = rpc & ~32'd3;
            buffered  = 0;
            dropflag  = pending;
        end else if (st) begin
            chk("stall_valid", 32'(id_valid), 32'(pv));
            chk("stall_pc", id_pc, ppc);
            chk("stall_pc4", id_pc4, ppc4);
            chk("stall_instr", id_instr, pinstr);
            if (a_rv) begin
                if (dropflag) dropflag = 0;
                else buffered = 1;
            end
        end else begin
            newi = (a_rv && !dropflag) || buffered;
            if (a_rv && dropflag) dropflag = 0;
            chk("id_valid", 32'(id_valid), 32'(newi));
            if (newi) begin
                chk("deliv_pc", id_pc, exp_deliv);
                exp_deliv = exp_deliv + 32'd4;
                buffered  = 0;
            end
        end
        if (id_valid) begin
            chk("id_instr_data", id_instr, memw(id_pc));
            chk("id_pc4_sum", id_pc4, id_pc + 32'd4);
        end else begin
            chk("bubble_nop", id_instr, NOP_INSTR);
        end
        hold_req  = req_n && !a_gnt && !a_rd;
        hold_addr = addr_n;
        pv        = id_valid;
        ppc       = id_pc;
        ppc4      = id_pc4;
        pinstr    = id_instr;
    endtask

    initial begin
        bit found;
        logic [31:0] rpc;
        imem_gnt    = 0;
        imem_rvalid = 0;
        imem_rdata  = '0;
        stall       = 0;
        redirect    = 0;
        redirect_pc = '0;
        accept_pct  = 100;
        lat_max     = 0;
        do_reset(0);

        // zero-wait memory streaming
        repeat (10) cycle(0, 0, '0, 0, d);

        // stall across an arriving response
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending && delay == 0) found = 1;
            else cycle(0, 0, '0, 0, d);
        end
        if (!found) timeout_fail("wait_rvalid");
        repeat (3) cycle(1, 0, '0, 0, d);
        repeat (6) cycle(0, 0, '0, 0, d);

        // gnt withheld
        accept_pct = 0;
        repeat (5) cycle(0, 0, '0, 0, d);
        accept_pct = 100;
        repeat (4) cycle(0, 0, '0, 0, d);

        // redirect while waiting for data
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 1, 32'h0000_0103, 1, d);
            found = d;
        end
        if (!found) timeout_fail("redir_wait");
        lat_max = 0;
        repeat (8) cycle(0, 0, '0, 0, d);

        // redirect with gnt, then redirect with stall
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 1, 32'h0000_4000, 2, d);
            found = d;
        end
        if (!found) timeout_fail("redir_gnt");
        repeat (6) cycle(0, 0, '0, 0, d);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 1, 32'h0000_0200, 0, d);
            found = d;
        end
        if (!found) timeout_fail("redir_stall");
        repeat (6) cycle(0, 0, '0, 0, d);

        // wrap at the top of the address space
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 1, 32'hFFFF_FFFC, 0, d);
            found = d;
        end
        if (!found) timeout_fail("redir_wrap");
        repeat (10) cycle(0, 0, '0, 0, d);

        // randomized traffic
        accept_pct = 70;
        lat_max    = 3;
        repeat (3000) begin
            rpc = $urandom_range(1) ? $urandom
                                    : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
            cycle($urandom_range(3) == 0, $urandom_range(15) == 0, rpc, 0, d);
        end

        // async reset while a response is outstanding
        accept_pct = 100;
        lat_max    = 2;
        repeat (4) cycle(0, 0, '0, 0, d);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, '0, 0, d);
            found = pending && delay > 0;
        end
        if (!found) timeout_fail("wait_pending");
        do_reset(1);
        lat_max = 0;
        repeat (8) cycle(0, 0, '0, 0, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
